pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage SimpleRISC core (IF, OF, ALU, DM, WB). Keeps a scoreboard of in-flight destination registers, stalls IF/OF on read-after-write hazards (the datapath has no forwarding), squashes wrong-path instructions on taken branches, and drains and freezes the pipeline on `hlt`. Sits beside the control unit and drives the enables of the PC, the IF/OF pipe register and the OF/ALU pipe register.

## Interface
- `REG_W`, 5: register-specifier width.
- `CNT_W`, 16: stall-counter width.

- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `of_valid`  in  1  OF holds a real instruction.
- `of_rs1`, `of_rs2`  in  REG_W each  source specifiers of the OF instruction.
- `of_rs1_used`, `of_rs2_used`  in  1 each  the OF instruction reads that source.
- `of_is_wb`  in  1  the OF instruction writes the register file.
- `of_rd`  in  REG_W  destination of the OF instruction.
- `of_is_halt`  in  1  the OF instruction is `hlt`.
- `alu_branch_taken`  in  1  the instruction in ALU is a taken branch.
- `pc_write`  out  1  PC may update.
- `ifof_write`  out  1  IF/OF register may load.
- `ifof_flush`  out  1  IF/OF register loads a NOP.
- `ofalu_bubble`  out  1  OF/ALU register loads a NOP (isWb=0, no memory op).
- `halted`  out  1  the core is frozen after `hlt`.
- `stall_count`  out  CNT_W  saturating count of RAW-stall cycles.

## Operation
- Scoreboard: three entries {valid, rd}, one each for ALU, DM and WB. Every cycle it shifts ALU→DM→WB, and WB drops out.
- The new ALU entry is {of_is_wb, of_rd} when the OF instruction issues. Otherwise it is invalid.
- The OF instruction issues when `of_valid & !hazard & !alu_branch_taken` and the state is RUN.
- The hazard check covers the WB entry: the register file writes at the clock edge, so a value in WB is not yet readable.
- `hazard` = (`of_rs1_used` and rs1 matches any valid entry) or (`of_rs2_used` and rs2 matches any valid entry), gated by `of_valid`. r0 gets no special treatment.
- FSM has three states: RUN, DRAIN, HALTED.
- RUN with `alu_branch_taken` (highest priority):
  - `pc_write=1`, `ifof_write=1`, `ifof_flush=1`, `ofalu_bubble=1`.
  - The instructions in OF and IF are squashed.
  - `stall_count` does not increment.
- RUN with `hazard`: `pc_write=0`, `ifof_write=0`, `ofalu_bubble=1`, `stall_count` +1 (saturates at all-ones).
- RUN with an issuing `hlt`: it passes as a normal instruction that does not write back. Then `pc_write=0`, `ifof_write=0`, and the next state is DRAIN.
- RUN otherwise: `pc_write=1`, `ifof_write=1`, `ifof_flush=0`, `ofalu_bubble=0`.
- DRAIN:
  - `pc_write=0`, `ifof_write=0`, `ofalu_bubble=1`.
  - Once all scoreboard entries are invalid and no branch is taken, go to HALTED.
  - If `alu_branch_taken`, the `hlt` was wrong-path. Apply the branch outputs (as in RUN) and return to RUN.
- HALTED: same outputs as DRAIN, `halted=1`. Only `rst` leaves this state.
- Reset:
  - State RUN, scoreboard all invalid, `stall_count=0`, `halted=0`.
  - While `rst` is high: `pc_write=0`, `ifof_write=1`, `ifof_flush=1`, `ofalu_bubble=1`, so the pipe registers fill with NOPs.
  - Reset mid-stall or mid-drain discards everything.

## Timing
- State, scoreboard and `stall_count` are registered. All control outputs are combinational from registered state plus the current OF/ALU inputs, and take effect on the same edge.
- A dependent instruction directly behind its producer stalls 3 cycles. With one independent instruction between them it stalls 2; with two between it stalls 1; with three or more it does not stall.
- Branch penalty: 2 squashed slots, with no stall cycles added.
- `hlt` issue to `halted=1`: 3 cycles after issue while the last older instruction drains; 4 if the `hlt` itself is counted.
- A branch and a hazard in the same cycle: the branch wins. The stalled instruction is squashed and not counted.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the FSM state enum {RUN, DRAIN, HALTED};
  - the scoreboard entry struct {valid, rd[REG_W-1:0]};
  - the NOP encoding constant used by the IF/OF and OF/ALU registers.
- One sub-module, `sb_match`: combinational compare of one source specifier against the three entries. Instantiate it twice, once for rs1 and once for rs2.

## Test plan
- Independent stream: `add r1`, `add r2`, `add r3` with disjoint sources → no stalls, `stall_count=0`.
- `add r4,…` then `sub r5,r4,r6` back-to-back → `pc_write=0` for 3 cycles, 3 bubbles, `stall_count=3`, then `sub` issues.
- `ld r7` followed by 2 independent instructions and then `add r8,r7,r7` → 1 stall cycle.
- Taken `beq` in ALU while OF has an r4 hazard → flush and bubble in the same cycle, no stall counted, the scoreboard ALU entry becomes invalid.
- `hlt` after `add r1` → DRAIN, then `halted=1` once the scoreboard is empty; `pc_write` stays 0 forever; `rst` returns to RUN.
- `hlt` directly behind a taken `b` → DRAIN is entered and then cancelled by the branch, `halted` stays 0, the PC loads the target.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the SimpleRISC pipeline hazard controller.
package pipe_ctrl_pkg;

  // Register-specifier width carried by a scoreboard entry.
  localparam int unsigned SB_REG_W = 5;

  // Scoreboard depth and slot positions (youngest first).
  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned SB_ALU   = 0;
  localparam int unsigned SB_DM    = 1;
  localparam int unsigned SB_WB    = 2;

  // SimpleRISC nop (opcode 5'b01101), loaded by IF/OF and OF/ALU on flush/bubble.
  localparam logic [31:0] NOP_INSN = 32'h6800_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [SB_REG_W-1:0] rd;
  } sb_entry_t;

  localparam sb_entry_t SB_ENTRY_NONE = '{valid: 1'b0, rd: {SB_REG_W{1'b0}}};

endpackage

// File: rtl/pipe_hazard_ctrl_sb_match.sv
// Compares one source specifier against every scoreboard entry.
module sb_match
  import pipe_ctrl_pkg::*;
(
  input  logic [SB_REG_W-1:0]             rs_i,
  input  sb_entry_t [SB_DEPTH-1:0]        entries_i,
  output logic                            match_o
);

  // Any valid in-flight destination equal to the source is a hit (r0 included).
  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (entries_i[i].valid && (entries_i[i].rd == rs_i)) begin
        match_o = 1'b1;
      end else begin
        match_o = match_o;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW-stall, branch-squash and halt-drain sequencing for the 5-stage SimpleRISC pipe.
// REG_W must equal pipe_ctrl_pkg::SB_REG_W, which sizes the scoreboard entries.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             of_valid_i,
  input  logic [REG_W-1:0] of_rs1_i,
  input  logic [REG_W-1:0] of_rs2_i,
  input  logic             of_rs1_used_i,
  input  logic             of_rs2_used_i,
  input  logic             of_is_wb_i,
  input  logic [REG_W-1:0] of_rd_i,
  input  logic             of_is_halt_i,
  input  logic             alu_branch_taken_i,
  output logic             pc_write_o,
  output logic             ifof_write_o,
  output logic             ifof_flush_o,
  output logic             ofalu_bubble_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_count_o
);

  state_e                  state_q, state_d;
  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  logic rs1_hit_s, rs2_hit_s;
  logic hazard_s, issue_s, drained_s;

  sb_match u_match_rs1 (.rs_i(of_rs1_i), .entries_i(sb_q), .match_o(rs1_hit_s));
  sb_match u_match_rs2 (.rs_i(of_rs2_i), .entries_i(sb_q), .match_o(rs2_hit_s));

  // No forwarding: a source is blocked until its producer has left WB.
  assign hazard_s = of_valid_i & ((of_rs1_used_i & rs1_hit_s) | (of_rs2_used_i & rs2_hit_s));
  assign issue_s  = (state_q == RUN) & of_valid_i & ~hazard_s & ~alu_branch_taken_i;
  // WB retires at this edge, so only ALU and DM still matter for the drain.
  assign drained_s = ~sb_q[SB_ALU].valid & ~sb_q[SB_DM].valid;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Scoreboard shift and RAW-stall counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q        <= {SB_DEPTH{SB_ENTRY_NONE}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // FSM next state: an issuing hlt starts the drain; a taken branch cancels it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (issue_s && of_is_halt_i) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (alu_branch_taken_i) begin
          state_d = RUN;
        end else if (drained_s) begin
          state_d = HALTED;
        end else begin
          state_d = DRAIN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // Scoreboard advance and saturating stall count (branch-squashed stalls are not counted).
  always_comb begin
    sb_d[SB_WB]        = sb_q[SB_DM];
    sb_d[SB_DM]        = sb_q[SB_ALU];
    sb_d[SB_ALU].valid = issue_s & of_is_wb_i & ~of_is_halt_i;
    sb_d[SB_ALU].rd    = of_rd_i;
    if ((state_q == RUN) && !alu_branch_taken_i && hazard_s &&
        (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // FSM outputs: pipe-register and PC enables from state plus current OF/ALU inputs.
  always_comb begin
    pc_write_o     = 1'b0;
    ifof_write_o   = 1'b0;
    ifof_flush_o   = 1'b0;
    ofalu_bubble_o = 1'b1;
    halted_o       = 1'b0;
    if (rst_i) begin
      ifof_write_o = 1'b1;
      ifof_flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (alu_branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifof_write_o = 1'b1;
            ifof_flush_o = 1'b1;
          end else if (hazard_s) begin
            ofalu_bubble_o = 1'b1;
          end else if (of_valid_i && of_is_halt_i) begin
            ofalu_bubble_o = 1'b0;
          end else begin
            pc_write_o     = 1'b1;
            ifof_write_o   = 1'b1;
            ofalu_bubble_o = 1'b0;
          end
        end
        DRAIN: begin
          if (alu_branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifof_write_o = 1'b1;
            ifof_flush_o = 1'b1;
          end else begin
            pc_write_o = 1'b0;
          end
        end
        HALTED:  halted_o = 1'b1;
        default: halted_o = 1'b0;
      endcase
    end
  end

  assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized self-checking bench for pipe_hazard_ctrl against a register-readiness model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, of_valid, rs1_used, rs2_used, is_wb, is_halt, br;
  logic [4:0] rs1, rs2, rd;

  logic        pc_write, ifof_write, ifof_flush, ofalu_bubble, halted;
  logic [15:0] stall_count;
  logic        s_pc_write, s_ifof_write, s_ifof_flush, s_ofalu_bubble, s_halted;
  logic [1:0]  s_stall_count;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .of_valid_i(of_valid), .of_rs1_i(rs1), .of_rs2_i(rs2),
    .of_rs1_used_i(rs1_used), .of_rs2_used_i(rs2_used), .of_is_wb_i(is_wb), .of_rd_i(rd),
    .of_is_halt_i(is_halt), .alu_branch_taken_i(br),
    .pc_write_o(pc_write), .ifof_write_o(ifof_write), .ifof_flush_o(ifof_flush),
    .ofalu_bubble_o(ofalu_bubble), .halted_o(halted), .stall_count_o(stall_count)
  );

  // Narrow counter copy so saturation is reachable.
  pipe_hazard_ctrl #(.REG_W(5), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .of_valid_i(of_valid), .of_rs1_i(rs1), .of_rs2_i(rs2),
    .of_rs1_used_i(rs1_used), .of_rs2_used_i(rs2_used), .of_is_wb_i(is_wb), .of_rd_i(rd),
    .of_is_halt_i(is_halt), .alu_branch_taken_i(br),
    .pc_write_o(s_pc_write), .ifof_write_o(s_ifof_write), .ifof_flush_o(s_ifof_flush),
    .ofalu_bubble_o(s_ofalu_bubble), .halted_o(s_halted), .stall_count_o(s_stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Model: ready_at[r] is the first cycle r is readable from the register file.
  int ready_at [32];
  int cyc;
  int mode;        // 0 running, 1 draining, 2 halted
  int halt_at;     // cycle halted becomes visible while draining
  int stall_m;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
    mode    = 0;
    stall_m = 0;
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] s1, input bit u1,
                      input logic [4:0] s2, input bit u2, input bit wb, input logic [4:0] d,
                      input bit hl, input bit b);
    bit hz, e_pc, e_w, e_f, e_b, e_h;
    int mx;
    @(negedge clk);
    rst = r; of_valid = v; rs1 = s1; rs1_used = u1; rs2 = s2; rs2_used = u2;
    is_wb = wb; rd = d; is_halt = hl; br = b;
    #1;
    check("stall_count", 32'(stall_count), 32'(stall_m));
    check("stall_count_sat", 32'(s_stall_count), 32'((stall_m > 3) ? 3 : stall_m));
    hz = v && ((u1 && ready_at[s1] > cyc) || (u2 && ready_at[s2] > cyc));
    e_h = 1'b0;
    if (r) begin
      {e_pc, e_w, e_f, e_b} = 4'b0111;
      model_reset();
    end else if (mode == 0) begin
      if (b) begin
        {e_pc, e_w, e_f, e_b} = 4'b1111;
      end else if (hz) begin
        {e_pc, e_w, e_f, e_b} = 4'b0001;
        stall_m++;
      end else if (v && hl) begin
        {e_pc, e_w, e_f, e_b} = 4'b0000;
        mx = cyc + 2;
        for (int i = 0; i < 32; i++) if (ready_at[i] > mx) mx = ready_at[i];
        halt_at = mx;
        mode = 1;
      end else begin
        {e_pc, e_w, e_f, e_b} = 4'b1100;
        if (v && wb) ready_at[d] = cyc + 4;
      end
    end else if (mode == 1) begin
      if (b) begin
        {e_pc, e_w, e_f, e_b} = 4'b1111;
        mode = 0;
      end else begin
        {e_pc, e_w, e_f, e_b} = 4'b0001;
        if (cyc + 1 >= halt_at) mode = 2;
      end
    end else begin
      {e_pc, e_w, e_f, e_b} = 4'b0001;
      e_h = 1'b1;
    end
    check("pc_write", 32'(pc_write), 32'(e_pc));
    check("ifof_write", 32'(ifof_write), 32'(e_w));
    check("ifof_flush", 32'(ifof_flush), 32'(e_f));
    check("ofalu_bubble", 32'(ofalu_bubble), 32'(e_b));
    check("halted", 32'(halted), 32'(e_h));
    cyc++;
  endtask

  // Shorthand for a register-writing instruction reading two sources.
  task automatic alu_op(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    step(0, 1, s1, 1, s2, 1, 1, d, 0, 0);
  endtask

  task automatic idle(input bit b);
    step(0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, b);
  endtask

  initial begin
    rst = 1'b1; of_valid = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    is_wb = 1'b0; rd = 5'd0; is_halt = 1'b0; br = 1'b0;
    cyc = 100;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state and reset-time outputs.
    step(1, 1, 5'd1, 1, 5'd2, 1, 1, 5'd3, 0, 0);

    // Independent stream.
    alu_op(5'd1, 5'd10, 5'd11);
    alu_op(5'd2, 5'd12, 5'd13);
    alu_op(5'd3, 5'd14, 5'd15);
    idle(0);
    check("indep_no_stall", 32'(stall_count), 32'd0);

    // Back-to-back RAW: sub held in OF for three stalls, then issues.
    alu_op(5'd4, 5'd10, 5'd11);
    repeat (4) alu_op(5'd5, 5'd4, 5'd6);
    idle(0);
    check("b2b_three_stalls", 32'(stall_count), 32'd3);

    // Load, two independents, then consumer: one stall.
    alu_op(5'd7, 5'd20, 5'd20);
    alu_op(5'd21, 5'd22, 5'd23);
    alu_op(5'd24, 5'd25, 5'd26);
    repeat (2) alu_op(5'd8, 5'd7, 5'd7);
    idle(0);
    check("gap2_one_stall", 32'(stall_count), 32'd4);

    // Branch in ALU while OF has an r4 hazard: branch wins, nothing counted.
    alu_op(5'd4, 5'd10, 5'd11);
    step(0, 1, 5'd4, 1, 5'd6, 1, 1, 5'd9, 0, 1);
    alu_op(5'd12, 5'd9, 5'd9);
    idle(0);
    check("branch_no_count", 32'(stall_count), 32'd4);
    repeat (3) idle(0);

    // hlt after add: drain then freeze; reset returns to run.
    alu_op(5'd1, 5'd2, 5'd3);
    step(0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    repeat (5) alu_op(5'd6, 5'd10, 5'd11);
    check("halt_frozen", 32'(halted), 32'd1);
    step(1, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0);
    alu_op(5'd6, 5'd10, 5'd11);

    // hlt behind a taken branch: drain cancelled, PC loads the target.
    step(0, 1, 5'd1, 1, 5'd2, 1, 0, 5'd0, 0, 0);
    step(0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0);
    idle(1);
    repeat (4) alu_op(5'd13, 5'd14, 5'd15);
    check("wrong_path_hlt_running", 32'(halted), 32'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      bit r, v, hl, b;
      r  = (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      hl = ($urandom_range(0, 39) == 0);
      b  = ($urandom_range(0, 7) == 0);
      step(r, v, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           hl ? 1'b0 : 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), hl, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
